dm_store_buffer: RTL

//   Store-side partner of the writeback path: accepts store requests (SB/SH/SW) from the MEM stage.

---
 rtl/dm_store_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: MEM-stage store queue. Each store is byte-aligned and given
// active-low byte enables when it is enqueued. The queue drains to data memory
// in program order over a req/ack handshake. A load is held while any store is
// still pending.
module dm_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic                       st_valid,
   input  logic [2:0]                 st_funct3,
   input  logic [AW-1:0]              st_addr,
   input  logic [DW-1:0]              st_data,
   output logic                       st_ready,
   output logic                       st_misalign,
   input  logic                       ld_valid,
   output logic                       ld_stall,
   output logic                       dm_req,
   output logic [AW-1:0]              dm_addr,
   output logic [DW-1:0]              dm_wdata,
   output logic [3:0]                 dm_web,
   input  logic                       dm_ack,
   output logic [$clog2(DEPTH+1)-1:0] sb_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0] addr_q [DEPTH];
   logic [AW-1:0] addr_d [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [DW-1:0] data_d [DEPTH];
   logic [3:0]    web_q  [DEPTH];
   logic [3:0]    web_d  [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          misalign_q, misalign_d;

   logic          aligned_s;
   logic [DW-1:0] al_data_s;
   logic [3:0]    al_web_s;
   logic          enq_s;
   logic          deq_s;

   // Byte-lane alignment and enable generation for the incoming store.
   always_comb begin
      aligned_s = 1'b0;
      al_data_s = {DW{1'b0}};
      al_web_s  = 4'hF;
      case (st_funct3)
         3'b000: begin
            aligned_s = 1'b1;
            al_data_s = {4{st_data[7:0]}};
            al_web_s  = ~(4'b0001 << st_addr[1:0]);
         end
         3'b001: begin
            aligned_s = ~st_addr[0];
            al_data_s = {2{st_data[15:0]}};
            al_web_s  = st_addr[1] ? 4'b0011 : 4'b1100;
         end
         3'b010: begin
            aligned_s = (st_addr[1:0] == 2'b00);
            al_data_s = st_data;
            al_web_s  = 4'b0000;
         end
         default: begin
            aligned_s = 1'b0;
            al_data_s = {DW{1'b0}};
            al_web_s  = 4'hF;
         end
      endcase
   end

   // Handshake outputs come straight from the registered head entry.
   always_comb begin
      st_ready    = (count_q != CW'(DEPTH));
      dm_req      = (count_q != {CW{1'b0}});
      dm_addr     = addr_q[rd_ptr_q];
      dm_wdata    = data_q[rd_ptr_q];
      dm_web      = dm_req ? web_q[rd_ptr_q] : 4'hF;
      ld_stall    = ld_valid & dm_req;
      st_misalign = misalign_q;
      sb_count    = count_q;
      enq_s       = st_valid & st_ready & aligned_s;
      deq_s       = dm_req & dm_ack;
   end

   // Next-state for queue storage, pointers, occupancy and the reject pulse.
   always_comb begin
      addr_d     = addr_q;
      data_d     = data_q;
      web_d      = web_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      misalign_d = st_valid & st_ready & ~aligned_s;
      if (enq_s) begin
         addr_d[wr_ptr_q] = {st_addr[AW-1:2], 2'b00};
         data_d[wr_ptr_q] = al_data_s;
         web_d[wr_ptr_q]  = al_web_s;
         wr_ptr_d         = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
         rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
   end

   // State registers; reset discards every pending entry.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= {AW{1'b0}};
            data_q[i] <= {DW{1'b0}};
            web_q[i]  <= 4'hF;
         end
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         misalign_q <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         data_q     <= data_d;
         web_q      <= web_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
      end
   end

endmodule
